interleaver_seq_ctrl: RTL
=========================

INTERLEAVER_SEQ_CTRL -- requirements
Module: interleaver_seq_ctrl

Interface
REQ-001 Parameter IND_W, default 14: width of the bit-index output, which is sufficient for 0..6143.
REQ-002 Parameter BCNT_W, default 10: width of the byte counter, which is sufficient for 0..767.
REQ-003 CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-004 KEY_0  input  1  reset; asynchronous, active-low.
REQ-005 k_size_6144  input  1  block size: 0 = 1056 bits, 1 = 6144 bits; sampled only at block start.
REQ-006 byte_valid  input  1  a byte is present on the upstream byte bus this cycle.
REQ-007 byte_ready  output  1  controller accepts a byte this cycle.
REQ-008 shift_en  output  1  enable for the 8-bit-wide input shift register; equals byte_valid AND byte_ready (combinational).
REQ-009 ready_in  input  1  downstream may take one serial bit pair this cycle.
REQ-010 abort  input  1  synchronous cancel of the current block.
REQ-011 mux_ind  output  IND_W  bit index driving both output muxes (outi and outpii).
REQ-012 out_valid  output  1  outi/outpii carry a valid bit at mux_ind.
REQ-013 k_lat  output  1  latched block size, driving the interleaver's K_eq_6144 for the whole block.
REQ-014 block_done  output  1  one-cycle pulse after the last bit is streamed.
REQ-015 state_led  output  3  one-hot LOAD/WAIT/STREAM indication for LEDR0..2.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT, STREAM and DONE, held in a registered state variable.
REQ-017 IDLE: byte_ready=1; on the first accepted byte, k_lat<=k_size_6144, bcnt<=1, and the FSM goes to LOAD; if NBYTES=1 it goes straight to WAIT.
REQ-018 NBYTES SHALL be 132 when k_lat=0 and 768 when k_lat=1.
REQ-019 LOAD: byte_ready=1; each accepted byte increments bcnt; the byte accepted while bcnt==NBYTES-1 moves the FSM to WAIT, and bcnt clears to 0.
REQ-020 LOAD without byte_valid SHALL hold state and bcnt (gaps allowed).
REQ-021 WAIT: byte_ready=0; the FSM stays for at least one full cycle (remap settle), then goes to STREAM on the first cycle ready_in=1, with mux_ind=0.
REQ-022 STREAM: out_valid=1; when ready_in=1, mux_ind increments by 1; when ready_in=0, mux_ind holds (stall).
REQ-023 In STREAM with ready_in=1 and mux_ind==K-1 (K=1056 or 6144 per k_lat), the FSM SHALL go to DONE; mux_ind SHALL never exceed K-1.
REQ-024 DONE: block_done=1 and out_valid=0 for exactly one cycle, then IDLE; byte_ready=0 in DONE.
REQ-025 byte_ready SHALL be 0 in WAIT, STREAM and DONE; bytes offered in those states are ignored and shift_en stays 0.
REQ-026 abort=1 in any state SHALL force IDLE next cycle, clear bcnt and mux_ind, and suppress block_done; abort has priority over the last-byte and last-bit transitions.
REQ-027 k_size_6144 changes after block start SHALL have no effect until the next IDLE acceptance.
REQ-028 Counter arithmetic SHALL be unsigned with no wrap; terminal compares use the latched K/NBYTES only.

Reset
REQ-029 KEY_0=0 SHALL asynchronously set: state=IDLE, bcnt=0, mux_ind=0, k_lat=0, out_valid=0, block_done=0, state_led=000.
REQ-030 Reset release SHALL take effect on the next rising edge of CLOCK_50; reset mid-LOAD or mid-STREAM discards the block.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, K_SMALL=1056, K_LARGE=6144, NB_SMALL=132, NB_LARGE=768 and IND_W.
REQ-032 The bit-index counter SHALL be the sub-module ind_gen_ctrl (enable, clear, terminal-count compare); the FSM and byte counter are inline.

Verification
REQ-033 k=0, 132 consecutive bytes, ready_in=1 -> WAIT after byte 132; mux_ind 0..1055 on consecutive cycles; block_done at cycle index 1056 of STREAM; then IDLE.
REQ-034 k=1, 768 bytes with a 1-cycle gap every 4th byte -> shift_en pulses exactly 768 times; k_lat=1; mux_ind ends at 6143.
REQ-035 STREAM with ready_in toggled 1,0,1,0 -> mux_ind sequence 0,1,1,2,2; out_valid stays 1.
REQ-036 abort at mux_ind=500, in the same cycle as ready_in=1 -> IDLE next cycle, mux_ind=0, no block_done.
REQ-037 KEY_0 low at byte 50 of a k=1 load -> immediate IDLE; a following k=0 block of 132 bytes completes normally.
REQ-038 k_size_6144 flipped 0->1 during a k=0 load -> still 132 bytes, K=1056, k_lat=0 throughout.

Source files
------------

// File: rtl/interleaver_seq_ctrl_pkg.sv
// Shared constants, FSM encoding and block-size helpers for the interleaver
// sequencing controller.
package interleaver_seq_ctrl_pkg;

  localparam int unsigned IND_W    = 14;
  localparam int unsigned BCNT_W   = 10;
  localparam int unsigned K_SMALL  = 1056;
  localparam int unsigned K_LARGE  = 6144;
  localparam int unsigned NB_SMALL = 132;
  localparam int unsigned NB_LARGE = 768;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  function automatic int unsigned nbytes_of(input logic k_sel);
    return k_sel ? NB_LARGE : NB_SMALL;
  endfunction

  function automatic int unsigned kbits_of(input logic k_sel);
    return k_sel ? K_LARGE : K_SMALL;
  endfunction

endpackage

// File: rtl/interleaver_seq_ctrl_if.sv
// Byte-load and bit-stream handshake bundle between the controller and its
// surroundings (byte source upstream, serial sink downstream).
interface interleaver_seq_ctrl_if #(
  parameter int unsigned IND_W = interleaver_seq_ctrl_pkg::IND_W
);
  logic             byte_valid;
  logic             byte_ready;
  logic             shift_en;
  logic             ready_in;
  logic             out_valid;
  logic [IND_W-1:0] mux_ind;

  // master: environment side; slave: the controller itself
  modport master (
    output byte_valid, ready_in,
    input  byte_ready, shift_en, out_valid, mux_ind
  );

  modport slave (
    input  byte_valid, ready_in,
    output byte_ready, shift_en, out_valid, mux_ind
  );
endinterface

// File: rtl/interleaver_seq_ctrl_ind_gen.sv
// Bit-index counter: counts 0..K-1 while enabled, flags the terminal index.
module ind_gen_ctrl
  import interleaver_seq_ctrl_pkg::*;
#(
  parameter int unsigned IND_W = interleaver_seq_ctrl_pkg::IND_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             k_sel,
  output logic [IND_W-1:0] ind,
  output logic             tc
);

  logic [IND_W-1:0] last;

  assign last = IND_W'(kbits_of(k_sel) - 1);
  assign tc   = (ind == last);

  // Wrapping to zero on the terminal step keeps the index within 0..K-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ind <= '0;
    else if (clr || (en && tc))
      ind <= '0;
    else if (en)
      ind <= ind + 1'b1;
  end

endmodule

// File: rtl/interleaver_seq_ctrl.sv
// Sequencing controller: loads one block of bytes, waits for the remap to
// settle, then streams bit indices 0..K-1 to the output muxes.
module interleaver_seq_ctrl
  import interleaver_seq_ctrl_pkg::*;
#(
  parameter int unsigned IND_W  = interleaver_seq_ctrl_pkg::IND_W,
  parameter int unsigned BCNT_W = interleaver_seq_ctrl_pkg::BCNT_W
) (
  input  logic                    CLOCK_50,
  input  logic                    KEY_0,
  input  logic                    k_size_6144,
  input  logic                    abort,
  interleaver_seq_ctrl_if.slave   bus,
  output logic                    k_lat,
  output logic                    block_done,
  output logic [2:0]              state_led
);

  state_t              state, state_nxt;
  logic [BCNT_W-1:0]   bcnt, bcnt_nxt, nb_last;
  logic                k_lat_nxt;
  logic                accept;
  logic                ind_en, ind_clr, ind_tc;
  logic [IND_W-1:0]    mux_ind;

  assign bus.byte_ready = (state == S_IDLE) || (state == S_LOAD);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign bus.shift_en   = accept;
  assign bus.out_valid  = (state == S_STREAM);
  assign bus.mux_ind    = mux_ind;
  assign block_done     = (state == S_DONE);
  assign state_led      = {state == S_STREAM, state == S_WAIT, state == S_LOAD};

  assign nb_last = BCNT_W'(nbytes_of(k_lat) - 1);
  assign ind_en  = (state == S_STREAM) && bus.ready_in;
  assign ind_clr = abort || (state != S_STREAM);

  ind_gen_ctrl #(
    .IND_W (IND_W)
  ) u_ind_gen (
    .clk   (CLOCK_50),
    .rst_n (KEY_0),
    .en    (ind_en),
    .clr   (ind_clr),
    .k_sel (k_lat),
    .ind   (mux_ind),
    .tc    (ind_tc)
  );

  always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
    if (!KEY_0) begin
      state <= S_IDLE;
      bcnt  <= '0;
      k_lat <= 1'b0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      k_lat <= k_lat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    k_lat_nxt = k_lat;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          k_lat_nxt = k_size_6144;
          if (nbytes_of(k_size_6144) == 1) begin
            state_nxt = S_WAIT;
            bcnt_nxt  = '0;
          end else begin
            state_nxt = S_LOAD;
            bcnt_nxt  = BCNT_W'(1);
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (bcnt == nb_last) begin
            state_nxt = S_WAIT;
            bcnt_nxt  = '0;
          end else begin
            bcnt_nxt  = bcnt + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (bus.ready_in)
          state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (bus.ready_in && ind_tc)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides every transition above, including last byte / last bit.
    if (abort) begin
      state_nxt = S_IDLE;
      bcnt_nxt  = '0;
    end
  end

endmodule
